vga_frame_decoder: RTL and testbench
====================================

// Module: vga_frame_decoder
// PURPOSE
//  Receive-side counterpart of the VGA display pipeline. Samples HSYNC, VSYNC and
//  the 9-bit RGB bus and recovers the pixel grid (X, Y) by locking to the sync pulses.
//  Checks the line and frame timing, and counts lit pixels per frame.
//  Used as an on-chip loopback monitor and as the checker for display-side benches.
// PARAMETERS
//  H_ACTIVE    640  visible pixels per line
//  H_FP        16   horizontal front porch (clocks)
//  H_SYNC      96   HSYNC low width (clocks)
//  H_BP        48   horizontal back porch (clocks)
//  V_ACTIVE    480  visible lines per frame
//  V_FP        10   vertical front porch (lines)
//  V_SYNC      2    VSYNC low width (lines)
//  V_BP        33   vertical back porch (lines)
//  LOCK_FRAMES 2    consecutive error-free frames required for lock (1..15)
// PORTS
//  Pixelclock  in   1   pixel clock; sole clock; all logic on the rising edge
//  reset       in   1   asynchronous, active-low reset
//  HSYNC       in   1   horizontal sync, active low, synchronous to Pixelclock
//  VSYNC       in   1   vertical sync, active low, synchronous to Pixelclock
//  RGB_in      in   9   {R[2:0],G[2:0],B[2:0]} pixel bus
//  X           out  10  recovered column, 0..H_ACTIVE-1
//  Y           out  9   recovered row, 0..V_ACTIVE-1
//  pixel_valid out  1   X/Y/RGB_pixel form a visible pixel, and the decoder is locked
//  RGB_pixel   out  9   RGB_in aligned with X/Y
//  frame_start out  1   1-cycle pulse at each frame boundary
//  locked      out  1   the timing lock FSM is in the LOCKED state
//  sync_err    out  1   1-cycle pulse on any detected timing violation
//  lit_count   out  19  count of valid pixels with RGB != 0 in the last completed frame
// BEHAVIOUR
//  Reset (reset=0): all outputs 0, counters 0, FSM=SEARCH, sampled syncs=1 (idle).
//  Input stage: HSYNC, VSYNC and RGB_in are registered once.
//   - hfall = previous sample 1 and current sample 0; vfall is defined the same way.
//  h_cnt (10b):
//   - hfall sets h_cnt to 0; otherwise it increments, saturating at 1023.
//   - h_cnt reaching 1023 pulses sync_err (lost HSYNC) and forces the FSM to SEARCH.
//  Line check: at hfall, if the old h_cnt+1 != H_TOTAL (=H_SYNC+H_BP+H_ACTIVE+H_FP),
//   pulse sync_err. The first hfall after SEARCH is exempt from this check.
//  v_cnt (10b), updated only at hfall:
//   - If vfall occurred since the last hfall (or occurs in the same cycle as it),
//     v_cnt is set to 0. This is the frame boundary.
//   - Otherwise v_cnt increments, saturating at 1023.
//  Frame boundary actions:
//   - Pulse frame_start.
//   - If the old v_cnt+1 != V_TOTAL and the FSM is not SEARCH, pulse sync_err.
//   - Load lit_count from the running counter, then clear the running counter.
//  Active window:
//   - hact = h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1].
//   - vact = v_cnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE-1].
//   - X = h_cnt-(H_SYNC+H_BP); Y = v_cnt-(V_SYNC+V_BP), both truncated to port width.
//   - X and Y hold 0 outside the window.
//  pixel_valid = hact & vact & locked.
//  Latency: X, Y, RGB_pixel and pixel_valid are mutually aligned, 2 Pixelclock cycles
//   after the pin sample. The first visible pixel of a line is RGB_in sampled on the
//   clock edge H_SYNC+H_BP cycles after the HSYNC-low sample.
//  Running lit counter: increments when pixel_valid=1 and RGB_pixel!=0. Max 307200.
//  Lock FSM (registered, 2 bits):
//   - SEARCH: the first frame boundary moves to VERIFY with good=0.
//   - VERIFY: a frame boundary with no sync_err since the previous boundary gives
//     good+1; when good reaches LOCK_FRAMES, move to LOCKED. A sync_err clears good.
//   - LOCKED: a sync_err moves to VERIFY, good=0. locked falls the cycle after the
//     sync_err pulse.
//   - A lost-HSYNC condition goes to SEARCH from any state.
//  Simultaneous events: the SEARCH transition takes priority over VERIFY/LOCKED.
//   When sync_err and a frame boundary occur together in VERIFY, the frame counts
//   as bad.
//  Reset mid-frame: everything returns to reset values; relock needs 1 boundary plus
//   LOCK_FRAMES clean frames.
// TESTING
//  1 Drive a standard 800x525 stream from the display controller with reset held
//    high -> locked rises at the 3rd frame boundary; sync_err is never pulsed.
//  2 Solid white frame (RGB_in=9'h1FF) while locked -> lit_count=307200 at the next
//    frame_start; all black -> 0.
//  3 Single lit pixel at X=5,Y=7 -> pixel_valid&&X==5&&Y==7 with RGB_pixel=9'h1FF,
//    2 cycles after it is driven; lit_count=1.
//  4 Shorten one line to 799 clocks while locked -> one sync_err pulse, locked drops;
//    relock after 2 clean frames.
//  5 Hold HSYNC high for 1100 cycles -> sync_err at h_cnt=1023, FSM=SEARCH, locked=0.
//  6 Assert reset=0 mid-frame for 3 cycles -> all outputs 0; same relock as scenario 1.

Source files
------------

// File: rtl/vga_frame_decoder.sv
// vga_frame_decoder
// Receive-side VGA monitor. Registers the sync/RGB pins, rebuilds the pixel grid
// from the falling edges of HSYNC/VSYNC, checks line and frame lengths, locks
// after a run of clean frames, and reports how many lit pixels the last frame had.
module vga_frame_decoder #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        Pixelclock,
    input  logic        reset,
    input  logic        HSYNC,
    input  logic        VSYNC,
    input  logic [8:0]  RGB_in,
    output logic [9:0]  X,
    output logic [8:0]  Y,
    output logic        pixel_valid,
    output logic [8:0]  RGB_pixel,
    output logic        frame_start,
    output logic        locked,
    output logic        sync_err,
    output logic [18:0] lit_count
);

    localparam logic [10:0] H_TOTAL_C = 11'(H_SYNC + H_BP + H_ACTIVE + H_FP);
    localparam logic [10:0] V_TOTAL_C = 11'(V_SYNC + V_BP + V_ACTIVE + V_FP);
    localparam logic [9:0]  H_START   = 10'(H_SYNC + H_BP);
    localparam logic [9:0]  H_END     = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [9:0]  V_START   = 10'(V_SYNC + V_BP);
    localparam logic [9:0]  V_END     = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
    localparam logic [3:0]  LOCK_C    = 4'(LOCK_FRAMES);

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    // pin samples and their one-cycle history (idle level is high)
    logic        hs_q, hs_p_q, vs_q, vs_p_q;
    logic [8:0]  rgb_s_q, rgb_d1_q;

    // timing counters
    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic        vpend_q, vpend_d;   // VSYNC fell since the last HSYNC fall
    logic        hchk_q, hchk_d;     // line length check armed

    // lock FSM
    logic [1:0]  state_q, state_d;
    logic [3:0]  good_q, good_d;
    logic        errseen_q, errseen_d;

    // lit pixel counting
    logic [18:0] run_q, run_d;
    logic [18:0] lit_q, lit_d;

    // output registers
    logic [9:0]  x_q, x_d;
    logic [8:0]  y_q, y_d;
    logic        pv_q, pv_d;
    logic [8:0]  rgbp_q;
    logic        fs_q;
    logic        locked_q;
    logic        err_q;

    // decoded events
    logic hfall_s, vfall_s, boundary_s, lost_s, line_err_s, frame_err_s, err_s;
    logic hact_s, vact_s;

    // Event decode from the registered pin samples
    always_comb begin
        hfall_s     = hs_p_q & ~hs_q;
        vfall_s     = vs_p_q & ~vs_q;
        boundary_s  = hfall_s & (vfall_s | vpend_q);
        lost_s      = ~hfall_s & (h_cnt_q == 10'd1022);
        line_err_s  = hfall_s & hchk_q & (({1'b0, h_cnt_q} + 11'd1) != H_TOTAL_C);
        frame_err_s = boundary_s & (state_q != ST_SEARCH)
                      & (({1'b0, v_cnt_q} + 11'd1) != V_TOTAL_C);
        err_s       = lost_s | line_err_s | frame_err_s;
    end

    // Next state of the horizontal/vertical counters and their flags
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        vpend_d = vpend_q;
        hchk_d  = hchk_q;
        if (hfall_s) begin
            h_cnt_d = 10'd0;
            vpend_d = 1'b0;
            hchk_d  = 1'b1;
            if (boundary_s) begin
                v_cnt_d = 10'd0;
            end else if (v_cnt_q != 10'd1023) begin
                v_cnt_d = v_cnt_q + 10'd1;
            end else begin
                v_cnt_d = v_cnt_q;
            end
        end else begin
            if (h_cnt_q != 10'd1023) begin
                h_cnt_d = h_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q;
            end
            if (vfall_s) begin
                vpend_d = 1'b1;
            end else begin
                vpend_d = vpend_q;
            end
            // after a lost line the next HSYNC fall only re-anchors the counter
            if (lost_s) begin
                hchk_d = 1'b0;
            end else begin
                hchk_d = hchk_q;
            end
        end
    end

    // Lock FSM: lost HSYNC wins over everything, a frame with an error counts as bad
    always_comb begin
        state_d   = state_q;
        good_d    = good_q;
        errseen_d = errseen_q | err_s;
        if (lost_s) begin
            state_d   = ST_SEARCH;
            good_d    = 4'd0;
            errseen_d = 1'b0;
        end else begin
            case (state_q)
                ST_SEARCH: begin
                    errseen_d = 1'b0;
                    if (boundary_s) begin
                        state_d = ST_VERIFY;
                        good_d  = 4'd0;
                    end else begin
                        state_d = ST_SEARCH;
                    end
                end
                ST_VERIFY: begin
                    if (boundary_s) begin
                        errseen_d = 1'b0;
                        if (errseen_q | err_s) begin
                            good_d = 4'd0;
                        end else if ((good_q + 4'd1) >= LOCK_C) begin
                            good_d  = good_q + 4'd1;
                            state_d = ST_LOCKED;
                        end else begin
                            good_d = good_q + 4'd1;
                        end
                    end else if (err_s) begin
                        good_d = 4'd0;
                    end else begin
                        good_d = good_q;
                    end
                end
                ST_LOCKED: begin
                    if (err_s) begin
                        state_d   = ST_VERIFY;
                        good_d    = 4'd0;
                        // the frame in progress already carries this error
                        errseen_d = ~boundary_s;
                    end else if (boundary_s) begin
                        errseen_d = 1'b0;
                    end else begin
                        errseen_d = errseen_q;
                    end
                end
                default: begin
                    state_d   = ST_SEARCH;
                    good_d    = 4'd0;
                    errseen_d = 1'b0;
                end
            endcase
        end
    end

    // Running lit counter, snapshotted into lit_count at each frame boundary
    always_comb begin
        run_d = run_q;
        lit_d = lit_q;
        if (boundary_s) begin
            lit_d = run_q;
            run_d = 19'd0;
        end else if (pv_q && (rgbp_q != 9'd0)) begin
            run_d = run_q + 19'd1;
        end else begin
            run_d = run_q;
        end
    end

    // Active window and pixel coordinates for the output stage
    always_comb begin
        hact_s = (h_cnt_q >= H_START) && (h_cnt_q <= H_END);
        vact_s = (v_cnt_q >= V_START) && (v_cnt_q <= V_END);
        x_d    = 10'd0;
        y_d    = 9'd0;
        if (hact_s) begin
            x_d = h_cnt_q - H_START;
        end else begin
            x_d = 10'd0;
        end
        if (vact_s) begin
            y_d = 9'(v_cnt_q - V_START);
        end else begin
            y_d = 9'd0;
        end
        pv_d = hact_s & vact_s & locked_q;
    end

    // Pin sampling; RGB gets one extra stage to line up with the counters
    always_ff @(posedge Pixelclock or negedge reset) begin
        if (!reset) begin
            hs_q     <= 1'b1;
            hs_p_q   <= 1'b1;
            vs_q     <= 1'b1;
            vs_p_q   <= 1'b1;
            rgb_s_q  <= 9'd0;
            rgb_d1_q <= 9'd0;
        end else begin
            hs_q     <= HSYNC;
            hs_p_q   <= hs_q;
            vs_q     <= VSYNC;
            vs_p_q   <= vs_q;
            rgb_s_q  <= RGB_in;
            rgb_d1_q <= rgb_s_q;
        end
    end

    // Timing counters, lock FSM and lit counters
    always_ff @(posedge Pixelclock or negedge reset) begin
        if (!reset) begin
            h_cnt_q   <= 10'd0;
            v_cnt_q   <= 10'd0;
            vpend_q   <= 1'b0;
            hchk_q    <= 1'b0;
            state_q   <= ST_SEARCH;
            good_q    <= 4'd0;
            errseen_q <= 1'b0;
            run_q     <= 19'd0;
            lit_q     <= 19'd0;
        end else begin
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            vpend_q   <= vpend_d;
            hchk_q    <= hchk_d;
            state_q   <= state_d;
            good_q    <= good_d;
            errseen_q <= errseen_d;
            run_q     <= run_d;
            lit_q     <= lit_d;
        end
    end

    // Registered outputs
    always_ff @(posedge Pixelclock or negedge reset) begin
        if (!reset) begin
            x_q      <= 10'd0;
            y_q      <= 9'd0;
            pv_q     <= 1'b0;
            rgbp_q   <= 9'd0;
            fs_q     <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            pv_q     <= pv_d;
            rgbp_q   <= rgb_d1_q;
            fs_q     <= boundary_s;
            locked_q <= (state_q == ST_LOCKED);
            err_q    <= err_s;
        end
    end

    assign X           = x_q;
    assign Y           = y_q;
    assign pixel_valid = pv_q;
    assign RGB_pixel   = rgbp_q;
    assign frame_start = fs_q;
    assign locked      = locked_q;
    assign sync_err    = err_q;
    assign lit_count   = lit_q;

endmodule

// File: tb/tb_vga_frame_decoder.sv
// Directed bench for vga_frame_decoder using a shrunken 18x13 timing so that
// many frames fit in a short run.
module tb_vga_frame_decoder;

    localparam int HA  = 10;
    localparam int HFP = 2;
    localparam int HS  = 3;
    localparam int HBP = 3;
    localparam int VA  = 8;
    localparam int VFP = 1;
    localparam int VS  = 2;
    localparam int VBP = 2;
    localparam int HT  = HS + HBP + HA + HFP;   // 18
    localparam int VT  = VS + VBP + VA + VFP;   // 13
    localparam int HSB = HS + HBP;              // 6
    localparam int VSB = VS + VBP;              // 4

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        hsync = 1'b1;
    logic        vsync = 1'b1;
    logic [8:0]  rgb   = 9'd0;
    logic [9:0]  X;
    logic [8:0]  Y;
    logic        pixel_valid;
    logic [8:0]  RGB_pixel;
    logic        frame_start;
    logic        locked;
    logic        sync_err;
    logic [18:0] lit_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int err_n = 0, fs_n = 0, val_n = 0, hit_n = 0;
    int hit_cyc = -1, err_cyc = -1, unlock_cyc = -1, drv_cyc = -1;
    int max_x = 0, max_y = 0;
    logic locked_prev = 1'b0;

    vga_frame_decoder #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .LOCK_FRAMES(2)
    ) dut (
        .Pixelclock (clk),
        .reset      (rst_n),
        .HSYNC      (hsync),
        .VSYNC      (vsync),
        .RGB_in     (rgb),
        .X          (X),
        .Y          (Y),
        .pixel_valid(pixel_valid),
        .RGB_pixel  (RGB_pixel),
        .frame_start(frame_start),
        .locked     (locked),
        .sync_err   (sync_err),
        .lit_count  (lit_count)
    );

    always #5 clk = ~clk;

    // cycle index, advanced at every active edge
    always @(posedge clk) cyc <= cyc + 1;

    // event recorder, sampled on the inactive edge
    always @(negedge clk) begin
        locked_prev <= locked;
        if (locked_prev && !locked) unlock_cyc <= cyc;
        if (sync_err) begin
            err_n   <= err_n + 1;
            err_cyc <= cyc;
        end
        if (frame_start) fs_n <= fs_n + 1;
        if (pixel_valid) begin
            val_n <= val_n + 1;
            if (int'(X) > max_x) max_x <= int'(X);
            if (int'(Y) > max_y) max_y <= int'(Y);
            if (X == 10'd5 && Y == 9'd7 && RGB_pixel == 9'h1FF) begin
                hit_n   <= hit_n + 1;
                hit_cyc <= cyc;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, want);
        end
    endtask

    task automatic check_idle();
        chk("rst_X",   32'(X), 32'd0);
        chk("rst_Y",   32'(Y), 32'd0);
        chk("rst_pv",  32'(pixel_valid), 32'd0);
        chk("rst_rgb", 32'(RGB_pixel), 32'd0);
        chk("rst_fs",  32'(frame_start), 32'd0);
        chk("rst_lck", 32'(locked), 32'd0);
        chk("rst_err", 32'(sync_err), 32'd0);
        chk("rst_lit", 32'(lit_count), 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            hsync = 1'b1;
            vsync = 1'b1;
            rgb   = 9'd0;
        end
    endtask

    // mode: 0 black, 1 white, 2 single pixel (5,7), 3 black with line 3 one clock short,
    // 4 checkerboard of 9'h001. rst_line >= 0 pulls reset low for 3 clocks mid line.
    task automatic drive_frame(input int mode, input int rst_line);
        int len, x, y;
        logic act;
        for (int l = 0; l < VT; l++) begin
            len = (mode == 3 && l == 3) ? HT - 1 : HT;
            for (int p = 0; p < len; p++) begin
                @(negedge clk);
                if (l == rst_line && p == 8) begin
                    chk("lit_before_reset", 32'(lit_count), 32'd40);
                    rst_n = 1'b0;
                end
                if (l == rst_line && p == 11) begin
                    check_idle();
                    rst_n = 1'b1;
                end
                x     = p - HSB;
                y     = l - VSB;
                act   = (x >= 0 && x < HA && y >= 0 && y < VA);
                hsync = (p >= HS);
                vsync = (l >= VS);
                rgb   = 9'd0;
                if (act) begin
                    case (mode)
                        1: rgb = 9'h1FF;
                        2: if (x == 5 && y == 7) begin
                               rgb     = 9'h1FF;
                               drv_cyc = cyc;
                           end
                        4: if (((x ^ y) & 1) == 1) rgb = 9'h001;
                        default: rgb = 9'd0;
                    endcase
                end
            end
        end
    endtask

    initial begin
        int e0, v0, h0, f0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_idle();
        rst_n = 1'b1;
        idle(2);

        // acquisition: lock at the third boundary
        drive_frame(0, -1);
        chk("f1_locked", 32'(locked), 32'd0);
        chk("f1_fs", fs_n, 1);
        drive_frame(0, -1);
        chk("f2_locked", 32'(locked), 32'd0);
        drive_frame(0, -1);
        chk("f3_locked", 32'(locked), 32'd1);
        chk("f3_fs", fs_n, 3);
        chk("clean_err", err_n, 0);

        // lit counting
        v0 = val_n;
        drive_frame(1, -1);
        chk("white_valid", val_n - v0, HA * VA);
        drive_frame(0, -1);
        chk("white_lit", 32'(lit_count), 32'd80);
        h0 = hit_n;
        drive_frame(2, -1);
        chk("black_lit", 32'(lit_count), 32'd0);
        chk("hit_count", hit_n - h0, 1);
        chk("hit_latency", hit_cyc - drv_cyc, 3);
        drive_frame(4, -1);
        chk("single_lit", 32'(lit_count), 32'd1);
        drive_frame(0, -1);
        chk("checker_lit", 32'(lit_count), 32'd40);
        chk("max_x", max_x, HA - 1);
        chk("max_y", max_y, VA - 1);

        // one short line while locked
        e0 = err_n;
        drive_frame(3, -1);
        chk("short_err", err_n - e0, 1);
        chk("short_locked", 32'(locked), 32'd0);
        chk("unlock_delay", unlock_cyc - err_cyc, 1);
        e0 = err_n;
        drive_frame(0, -1);
        chk("relock_f1", 32'(locked), 32'd0);
        drive_frame(0, -1);
        chk("relock_f2", 32'(locked), 32'd0);
        drive_frame(0, -1);
        chk("relock_f3", 32'(locked), 32'd1);
        chk("relock_err", err_n - e0, 0);

        // HSYNC lost for 1100 clocks
        e0 = err_n;
        idle(1100);
        chk("lost_err", err_n - e0, 1);
        chk("lost_locked", 32'(locked), 32'd0);
        chk("lost_pv", 32'(pixel_valid), 32'd0);
        e0 = err_n;
        drive_frame(0, -1);
        drive_frame(0, -1);
        chk("search_f2", 32'(locked), 32'd0);
        drive_frame(4, -1);
        chk("search_f3", 32'(locked), 32'd1);
        chk("search_err", err_n - e0, 0);

        // reset in the middle of a frame
        e0 = err_n;
        f0 = fs_n;
        drive_frame(0, 6);
        chk("rst_frame_fs", fs_n - f0, 1);
        chk("rst_frame_lck", 32'(locked), 32'd0);
        drive_frame(0, -1);
        chk("rst_f1_locked", 32'(locked), 32'd0);
        chk("rst_f1_lit", 32'(lit_count), 32'd0);
        drive_frame(0, -1);
        chk("rst_f2_locked", 32'(locked), 32'd0);
        drive_frame(0, -1);
        chk("rst_f3_locked", 32'(locked), 32'd1);
        chk("rst_err", err_n - e0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
